pc_sequencer: RTL and testbench

Multi-cycle fetch/advance controller for the CPU's program counter. It fetches each instruction over an instruction-memory request/ready handshake and holds it in an instruction register. It waits for the datapath to finish executing, then issues exactly one PC update per instruction. Each update carries a `pc_control` code (sequential, J, JR, or taken branch) plus the jump and branch fields. It sits between instruction memory, the execute datapath and the program counter. The program counter advances only on `pc_step`.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/instr_classifier.sv | 23 ++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct fields, PC mux encodings,
// sequencer FSM states and instruction classes.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [2:0] PC_SEQ   = 3'b000;
  localparam logic [2:0] PC_J     = 3'b001;
  localparam logic [2:0] PC_JR    = 3'b010;
  localparam logic [2:0] PC_BR    = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_SEQ,
    CLS_JMP,
    CLS_JREG,
    CLS_BEQ,
    CLS_BNE
  } instr_class_t;

endpackage

// File: rtl/instr_classifier.sv
// Maps opcode/funct fields to the control-flow class the PC sequencer needs.
module instr_classifier
  import cpu_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class
);

  always_comb begin
    instr_class = CLS_SEQ;
    case (opcode)
      OP_J, OP_JAL: instr_class = CLS_JMP;
      OP_BEQ:       instr_class = CLS_BEQ;
      OP_BNE:       instr_class = CLS_BNE;
      OP_RTYPE: begin
        if (funct == FN_JR || funct == FN_JALR) instr_class = CLS_JREG;
      end
      default:      instr_class = CLS_SEQ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/exec/update controller issuing one PC update
// per instruction, with a sticky fetch-timeout fault.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        ex_done,
  input  logic        rs_eq_rt,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [2:0]  pc_control,
  output logic        pc_step,
  output logic [25:0] jmp_addr,
  output logic [15:0] branch_offset,
  output logic [31:0] retired,
  output logic        fault
);

  localparam int CW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT =
    (FETCH_TIMEOUT > 0) ? CW'(FETCH_TIMEOUT - 1) : '0;

  state_t       state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg;
  logic [31:0]  instr_reg;
  logic [31:0]  retired_reg;
  instr_class_t class_reg;
  instr_class_t class_comb;
  logic         timeout_hit;

  instr_classifier u_classifier (
    .opcode      (instr_reg[31:26]),
    .funct       (instr_reg[5:0]),
    .instr_class (class_comb)
  );

  assign timeout_hit = (FETCH_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   state_next = ST_FETCH;
      // Ready takes priority over a timeout landing in the same cycle.
      ST_FETCH: begin
        if (imem_ready)       state_next = ST_DECODE;
        else if (timeout_hit) state_next = ST_FAULT;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   if (ex_done) state_next = ST_UPDATE;
      ST_UPDATE: state_next = ST_FETCH;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state_reg == ST_FETCH);
    instr_valid = (state_reg == ST_EXEC) || (state_reg == ST_UPDATE);
    pc_step     = (state_reg == ST_UPDATE);
    fault       = (state_reg == ST_FAULT);
    pc_control  = PC_SEQ;
    if (state_reg == ST_UPDATE) begin
      case (class_reg)
        CLS_JMP:  pc_control = PC_J;
        CLS_JREG: pc_control = PC_JR;
        CLS_BEQ:  pc_control = rs_eq_rt  ? PC_BR : PC_SEQ;
        CLS_BNE:  pc_control = !rs_eq_rt ? PC_BR : PC_SEQ;
        default:  pc_control = PC_SEQ;
      endcase
    end
  end

  // The counter is held at zero outside FETCH, so every FETCH entry starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      instr_reg    <= '0;
      class_reg    <= CLS_SEQ;
      retired_reg  <= '0;
    end else begin
      if (state_reg == ST_FETCH && !imem_ready) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                                      wait_cnt_reg <= '0;
      if (state_reg == ST_FETCH && imem_ready) instr_reg <= imem_rdata;
      if (state_reg == ST_DECODE)              class_reg <= class_comb;
      if (state_reg == ST_UPDATE)              retired_reg <= retired_reg + 32'd1;
    end
  end

  assign instr         = instr_reg;
  assign retired       = retired_reg;
  assign jmp_addr      = instr_reg[25:0];
  assign branch_offset = instr_reg[15:0];

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues expected PC updates,
// a monitor checks each pc_step strobe against the queue.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ex_done;
  logic        rs_eq_rt;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  pc_control;
  logic        pc_step;
  logic [25:0] jmp_addr;
  logic [15:0] branch_offset;
  logic [31:0] retired;
  logic        fault;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [25:0] jmp;
    logic [15:0] boff;
    logic [31:0] ret;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;

  pc_sequencer #(.FETCH_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .ex_done(ex_done), .rs_eq_rt(rs_eq_rt),
    .instr(instr), .instr_valid(instr_valid), .pc_control(pc_control),
    .pc_step(pc_step), .jmp_addr(jmp_addr), .branch_offset(branch_offset),
    .retired(retired), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every PC update strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && pc_step === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got pc_step=1, expected no update");
      end else begin
        mon_e = exp_q.pop_front();
        check("upd_pc_control", {29'd0, pc_control}, {29'd0, mon_e.ctrl});
        check("upd_jmp_addr", {6'd0, jmp_addr}, {6'd0, mon_e.jmp});
        check("upd_branch_offset", {16'd0, branch_offset}, {16'd0, mon_e.boff});
        check("upd_retired_before", retired, mon_e.ret);
      end
    end
  end

  task automatic wait_req();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("wait_imem_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_step();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (pc_step === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("wait_pc_step_timeout", 32'd0, 32'd1);
  endtask

  // One instruction: ready arrives in FETCH cycle ready_cycle, EXEC stalls
  // for stall cycles with rs_eq_rt inverted until just before UPDATE.
  task automatic run_instr(input logic [31:0] word, input logic eq, input logic [2:0] ctrl,
                           input logic [25:0] jmp, input logic [15:0] boff,
                           input int ready_cycle, input int stall);
    exp_t e;
    ex_done  = (stall == 0);
    rs_eq_rt = (stall == 0) ? eq : !eq;
    wait_req();
    for (int i = 1; i < ready_cycle; i++) @(negedge clk);
    if (ready_cycle > 1) check("late_ready_no_fault", {31'd0, fault}, 32'd0);
    imem_rdata = word;
    imem_ready = 1'b1;
    e.ctrl = ctrl; e.jmp = jmp; e.boff = boff; e.ret = exp_retired;
    exp_q.push_back(e);
    @(negedge clk);
    imem_ready = 1'b0;
    check("captured_instr", instr, word);
    if (stall > 0) begin
      @(negedge clk);
      for (int i = 0; i < stall; i++) begin
        check("stall_pc_step", {31'd0, pc_step}, 32'd0);
        check("stall_instr_valid", {31'd0, instr_valid}, 32'd1);
        if (i < stall - 1) @(negedge clk);
      end
      ex_done  = 1'b1;
      rs_eq_rt = eq;
    end
    wait_step();
    exp_retired++;
    @(negedge clk);
    check("retired_after", retired, exp_retired);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_pc_control"}, {29'd0, pc_control}, 32'd0);
    check({tag, "_pc_step"}, {31'd0, pc_step}, 32'd0);
    check({tag, "_retired"}, retired, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'd0; ex_done = 1'b0; rs_eq_rt = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Mid-operation reset during EXEC: the instruction is discarded.
    wait_req();
    imem_rdata = 32'h08100004; imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    check("midrst_in_exec", {31'd0, instr_valid}, 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");

    // Restart: sequential word, pc_step in the 5th cycle after release.
    imem_ready = 1'b1; imem_rdata = 32'h00000000; ex_done = 1'b1; rs_eq_rt = 1'b0;
    exp_q.push_back('{ctrl: 3'b000, jmp: 26'd0, boff: 16'd0, ret: 32'd0});
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) check("seq_fetch_req_c2", {31'd0, imem_req}, 32'd1);
      if (k == 3) imem_ready = 1'b0;
      if (k == 4) check("seq_step_c4", {31'd0, pc_step}, 32'd0);
      if (k == 5) check("seq_step_c5", {31'd0, pc_step}, 32'd1);
    end
    exp_retired = 1;
    @(negedge clk);
    check("seq_retired", retired, 32'd1);

    run_instr(32'h08100004, 1'b0, 3'b001, 26'h0100004, 16'h0004, 1, 0);  // J
    run_instr(32'h03E00008, 1'b0, 3'b010, 26'h3E00008, 16'h0008, 1, 0);  // JR $ra
    run_instr(32'h1085FFFF, 1'b1, 3'b011, 26'h085FFFF, 16'hFFFF, 1, 0);  // BEQ taken
    run_instr(32'h1085FFFF, 1'b0, 3'b000, 26'h085FFFF, 16'hFFFF, 1, 0);  // BEQ not taken
    run_instr(32'h1485FFFF, 1'b0, 3'b011, 26'h085FFFF, 16'hFFFF, 1, 7);  // BNE, 7-cycle stall
    run_instr(32'h0060F809, 1'b0, 3'b010, 26'h060F809, 16'hF809, 8, 0);  // JALR, ready at timeout

    // Fetch timeout: 8 FETCH cycles without ready, then sticky fault.
    imem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req !== 1'b1) break;
      n++;
      @(negedge clk);
    end
    check("timeout_fetch_cycles", n, 32'd8);
    check("timeout_fault", {31'd0, fault}, 32'd1);
    check("timeout_imem_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1; ex_done = 1'b1;
    repeat (10) @(negedge clk);
    check("fault_hold", {29'd0, fault, imem_req, pc_step}, 32'd4);
    imem_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check("fault_cleared", {31'd0, fault}, 32'd0);
    check("fault_rst_retired", retired, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
